// File: rtl/multi_port_compress_fifo.sv
// N-in / M-out compressing FIFO: up to WRITE_PORT in-order pushes and READ_PORT oldest-first pops per cycle.
// Read lanes, occupancy and write_ready_o are registered; same-cycle writes forward into the read lanes.
module multi_port_compress_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int WRITE_PORT = 4,
  parameter int READ_PORT  = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush_i,
  input  logic                                write_valid_i,
  output logic                                write_ready_o,
  input  logic [$clog2(WRITE_PORT+1)-1:0]     write_num_i,
  input  logic [WRITE_PORT*DATA_WIDTH-1:0]    write_data_i,
  output logic [READ_PORT-1:0]                read_valid_o,
  input  logic                                read_ready_i,
  input  logic [$clog2(READ_PORT+1)-1:0]      read_num_i,
  output logic [READ_PORT*DATA_WIDTH-1:0]     read_data_o,
  output logic [$clog2(DEPTH):0]              count_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int WNW = $clog2(WRITE_PORT + 1);
  localparam int RNW = $clog2(READ_PORT + 1);
  localparam int DW  = DATA_WIDTH;

  function automatic logic [RNW-1:0] popcount(input logic [READ_PORT-1:0] v);
    logic [RNW-1:0] c;
    c = {RNW{1'b0}};
    for (int k = 0; k < READ_PORT; k++) begin
      c = c + RNW'(v[k]);
    end
    return c;
  endfunction

  logic [DW-1:0]           mem_r [DEPTH];
  logic [PW-1:0]           wr_ptr_r;
  logic [PW-1:0]           rd_ptr_r;
  logic [PW-1:0]           wr_ptr_next_s;
  logic [PW-1:0]           rd_ptr_next_s;
  logic [PW-1:0]           count_next_s;
  logic                    push_s;
  logic [WNW-1:0]          push_n_s;
  logic [RNW-1:0]          avail_s;
  logic [RNW-1:0]          pop_n_s;
  logic                    ready_next_s;
  logic [READ_PORT-1:0]    valid_next_s;
  logic [READ_PORT*DW-1:0] data_next_s;
  logic [PW-1:0]           slot_s  [READ_PORT];
  logic [PW-1:0]           off_s   [READ_PORT];
  logic [AW-1:0]           wslot_s [WRITE_PORT];

  // Accepted push/pop counts and post-update pointers; over-pop is clamped to what is presented.
  always_comb begin
    push_s = write_valid_i & write_ready_o;
    if (!push_s) begin
      push_n_s = {WNW{1'b0}};
    end else if (write_num_i > WNW'(WRITE_PORT)) begin
      push_n_s = WNW'(WRITE_PORT);
    end else begin
      push_n_s = write_num_i;
    end
    avail_s = popcount(read_valid_o);
    if (!read_ready_i) begin
      pop_n_s = {RNW{1'b0}};
    end else if (read_num_i > avail_s) begin
      pop_n_s = avail_s;
    end else begin
      pop_n_s = read_num_i;
    end
    wr_ptr_next_s = wr_ptr_r + PW'(push_n_s);
    rd_ptr_next_s = rd_ptr_r + PW'(pop_n_s);
    count_next_s  = wr_ptr_next_s - rd_ptr_next_s;
    ready_next_s  = (count_next_s <= PW'(DEPTH - WRITE_PORT));
    for (int j = 0; j < WRITE_PORT; j++) begin
      wslot_s[j] = wr_ptr_r[AW-1:0] + AW'(j);
    end
  end

  // Next read lanes: array contents, overridden by a lane being written this very cycle.
  always_comb begin
    valid_next_s = {READ_PORT{1'b0}};
    data_next_s  = {(READ_PORT*DW){1'b0}};
    for (int i = 0; i < READ_PORT; i++) begin
      slot_s[i]                = rd_ptr_next_s + PW'(i);
      off_s[i]                 = slot_s[i] - wr_ptr_r;
      valid_next_s[i]          = (count_next_s > PW'(i));
      data_next_s[i*DW +: DW]  = mem_r[slot_s[i][AW-1:0]];
      for (int j = 0; j < WRITE_PORT; j++) begin
        data_next_s[i*DW +: DW] = ((off_s[i] == PW'(j)) && (PW'(j) < PW'(push_n_s))) ?
                                  write_data_i[j*DW +: DW] : data_next_s[i*DW +: DW];
      end
    end
  end

  // Storage array write; not reset, and a flush discards the push.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      for (int j = 0; j < WRITE_PORT; j++) begin
        if (PW'(j) < PW'(push_n_s)) begin
          mem_r[wslot_s[j]] <= write_data_i[j*DW +: DW];
        end
      end
    end
  end

  // Pointers and registered outputs; flush clears occupancy but holds the read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r      <= {PW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      count_o       <= {PW{1'b0}};
      read_valid_o  <= {READ_PORT{1'b0}};
      write_ready_o <= 1'b1;
      read_data_o   <= {(READ_PORT*DW){1'b0}};
    end else if (flush_i) begin
      wr_ptr_r      <= {PW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      count_o       <= {PW{1'b0}};
      read_valid_o  <= {READ_PORT{1'b0}};
      write_ready_o <= 1'b1;
      read_data_o   <= read_data_o;
    end else begin
      wr_ptr_r      <= wr_ptr_next_s;
      rd_ptr_r      <= rd_ptr_next_s;
      count_o       <= count_next_s;
      read_valid_o  <= valid_next_s;
      write_ready_o <= ready_next_s;
      read_data_o   <= data_next_s;
    end
  end

  multi_port_compress_fifo_chk #(
    .READ_PORT (READ_PORT)
  ) u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .read_ready_i (read_ready_i),
    .read_num_i   (read_num_i),
    .read_valid   (read_valid_o)
  );

endmodule

// Checker for the FIFO: flags a pop request larger than the number of presented entries.
module multi_port_compress_fifo_chk #(
  parameter int READ_PORT = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush_i,
  input  logic                               read_ready_i,
  input  logic [$clog2(READ_PORT+1)-1:0]     read_num_i,
  input  logic [READ_PORT-1:0]               read_valid
);

  logic over_pop_s;

  assign over_pop_s = rst_n & ~flush_i & read_ready_i &
                      (int'(read_num_i) > $countones(read_valid));

  // Over-pop is legal (the design clamps it) but worth reporting.
  always @(posedge clk) begin
    if (rst_n) begin
      over_pop_a: assert (!over_pop_s)
        else $warning("over-pop clamped: read_num=%0d presented=%0d", read_num_i, $countones(read_valid));
    end
  end

endmodule
